// File: rtl/k423_wb_stage_pkg.sv
// Shared types for the k423 write-back stage: load-size encodings and the WB FSM state.
package k423_wb_stage_pkg;

  localparam int unsigned CORE_XLEN     = 32;
  localparam int unsigned CORE_ADDR_W   = 32;
  localparam int unsigned INST_RSDIDX_W = 5;

  typedef logic [1:0] ls_size_t;

  // 2'b11 is reserved and decodes as a word.
  localparam ls_size_t LS_SIZE_B = 2'b00;
  localparam ls_size_t LS_SIZE_H = 2'b01;
  localparam ls_size_t LS_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StWait
  } wb_state_e;

endpackage

// File: rtl/k423_wb_stage_if.sv
// ex2wb handshake, data-memory response and commit outputs of the write-back stage.
interface k423_wb_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RIDX_W = 5
);

  logic              ex2wb_stage_vld_i;
  logic              wb_stage_rdy_o;
  logic [ADDR_W-1:0] wb_pc_i;
  logic              wb_rd_vld_i;
  logic [RIDX_W-1:0] wb_rd_idx_i;
  logic [XLEN-1:0]   wb_rd_i;
  logic              wb_rd_load_i;
  logic [1:0]        wb_rd_load_size_i;
  logic              wb_rd_load_unsigned_i;
  logic [ADDR_W-1:0] wb_rd_load_addr_i;
  logic              dmem_rsp_vld_i;
  logic [XLEN-1:0]   dmem_rsp_data_i;
  logic              rf_wr_en_o;
  logic [RIDX_W-1:0] rf_wr_idx_o;
  logic [XLEN-1:0]   rf_wr_data_o;
  logic              wb_retire_vld_o;
  logic [ADDR_W-1:0] wb_retire_pc_o;

  // Upstream pipeline register plus data memory.
  modport master (
    output ex2wb_stage_vld_i, wb_pc_i, wb_rd_vld_i, wb_rd_idx_i, wb_rd_i, wb_rd_load_i,
           wb_rd_load_size_i, wb_rd_load_unsigned_i, wb_rd_load_addr_i,
           dmem_rsp_vld_i, dmem_rsp_data_i,
    input  wb_stage_rdy_o, rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o,
           wb_retire_vld_o, wb_retire_pc_o
  );

  modport slave (
    input  ex2wb_stage_vld_i, wb_pc_i, wb_rd_vld_i, wb_rd_idx_i, wb_rd_i, wb_rd_load_i,
           wb_rd_load_size_i, wb_rd_load_unsigned_i, wb_rd_load_addr_i,
           dmem_rsp_vld_i, dmem_rsp_data_i,
    output wb_stage_rdy_o, rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o,
           wb_retire_vld_o, wb_retire_pc_o
  );

endinterface

// File: rtl/k423_load_align.sv
// Combinational load-data alignment: shift the word by the byte offset, then sign/zero extend.
module k423_load_align
  import k423_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  ls_size_t        size,
  input  logic            is_unsigned,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [4:0]      sh;
  logic [XLEN-1:0] w;
  logic            unused_w_hi;

  assign sh          = {addr_lo, 3'b000};
  assign w           = data >> sh;
  assign unused_w_hi = ^w[XLEN-1:16];

  // Misaligned halves still shift by the full byte offset; no fault is raised here.
  always_comb begin
    result = data;
    case (size)
      LS_SIZE_B: result = {{(XLEN-8){~is_unsigned & w[7]}}, w[7:0]};
      LS_SIZE_H: result = {{(XLEN-16){~is_unsigned & w[15]}}, w[15:0]};
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/k423_wb_stage.sv
// Write-back stage: accepts the ex2wb bundle, matches loads with their memory response
// (live or buffered), and commits rf write + retire one cycle later.
// Optional K423_WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter port.
module k423_wb_stage
  import k423_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN   = CORE_XLEN,
  parameter int unsigned ADDR_W = CORE_ADDR_W,
  parameter int unsigned RIDX_W = INST_RSDIDX_W
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  k423_wb_stage_if.slave bus
`ifdef K423_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]    wb_instret_o
`endif
);

  wb_state_e         state_q, state_d;
  logic [XLEN-1:0]   rsp_buf_q;

  logic              load_in_wb;
  logic              rsp_avail;
  logic              rdy;
  logic              commit;
  logic              use_buf;
  logic              buf_we;
  logic [XLEN-1:0]   rsp_data;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   wr_data;

  logic              rf_wr_en_q;
  logic [RIDX_W-1:0] rf_wr_idx_q;
  logic [XLEN-1:0]   rf_wr_data_q;
  logic              retire_vld_q;
  logic [ADDR_W-1:0] retire_pc_q;

  logic              unused_addr_hi;

  assign load_in_wb     = bus.ex2wb_stage_vld_i & bus.wb_rd_load_i;
  assign unused_addr_hi = ^bus.wb_rd_load_addr_i[ADDR_W-1:2];

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_in_wb) begin
          if (!bus.dmem_rsp_vld_i) state_d = StWait;
        end else if (bus.dmem_rsp_vld_i) begin
          state_d = StHeld;
        end
      end
      StHeld: if (load_in_wb) state_d = StIdle;
      StWait: if (bus.dmem_rsp_vld_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs. A response with no load waiting is parked (or overwrites the parked one).
  always_comb begin
    use_buf   = (state_q == StHeld);
    rsp_avail = bus.dmem_rsp_vld_i | use_buf;
    rdy       = ~(load_in_wb & ~rsp_avail);
    commit    = bus.ex2wb_stage_vld_i & rdy;
    buf_we    = bus.dmem_rsp_vld_i & ~load_in_wb;
  end

  assign bus.wb_stage_rdy_o = rdy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_buf_q <= '0;
    end else if (buf_we) begin
      rsp_buf_q <= bus.dmem_rsp_data_i;
    end
  end

  assign rsp_data = use_buf ? rsp_buf_q : bus.dmem_rsp_data_i;

  k423_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .size        (bus.wb_rd_load_size_i),
    .is_unsigned (bus.wb_rd_load_unsigned_i),
    .addr_lo     (bus.wb_rd_load_addr_i[1:0]),
    .data        (rsp_data),
    .result      (load_data)
  );

  assign wr_data = bus.wb_rd_load_i ? load_data : bus.wb_rd_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_idx_q  <= '0;
      rf_wr_data_q <= '0;
      retire_vld_q <= 1'b0;
      retire_pc_q  <= '0;
    end else begin
      rf_wr_en_q   <= commit & bus.wb_rd_vld_i & (bus.wb_rd_idx_i != '0);
      retire_vld_q <= commit;
      if (commit) begin
        rf_wr_idx_q  <= bus.wb_rd_idx_i;
        rf_wr_data_q <= wr_data;
        retire_pc_q  <= bus.wb_pc_i;
      end
    end
  end

  assign bus.rf_wr_en_o      = rf_wr_en_q;
  assign bus.rf_wr_idx_o     = rf_wr_idx_q;
  assign bus.rf_wr_data_o    = rf_wr_data_q;
  assign bus.wb_retire_vld_o = retire_vld_q;
  assign bus.wb_retire_pc_o  = retire_pc_q;

`ifdef K423_WB_RETIRE_CNT_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instret_q <= '0;
    end else if (retire_vld_q) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign wb_instret_o = instret_q;
`endif

`ifndef SYNTHESIS
  // A second response while one is parked and not being consumed is a protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!(state_q == StHeld && bus.dmem_rsp_vld_i && !load_in_wb))
        else $error("k423_wb_stage: dmem response overwrote an unconsumed buffered response");
    end
  end
`endif

endmodule

// File: tb/tb_k423_wb_stage.sv
// Scoreboard bench for k423_wb_stage: directed cases then randomized loads/non-loads with
// same-cycle, late and early memory responses, checked against a behavioural model.
module tb_k423_wb_stage;
  import k423_wb_stage_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RIDX_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  k423_wb_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RIDX_W(RIDX_W)) bus ();

`ifdef K423_WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  k423_wb_stage #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .RIDX_W (RIDX_W)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
`ifdef K423_WB_RETIRE_CNT_EN
    ,
    .wb_instret_o (instret)
`endif
  );

  typedef struct {
    logic              en;
    logic [RIDX_W-1:0] idx;
    logic [XLEN-1:0]   data;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_retired = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: pick the addressed byte/half by arithmetic, then extend.
  function automatic logic [31:0] model_load(input int size, input bit uns,
                                             input int off, input logic [31:0] data);
    longint v;
    logic [31:0] w;
    w = data >> (8 * off);
    if (size == 0) begin
      v = longint'(w % 256);
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = longint'(w % 65536);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(data);
    end
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    bus.ex2wb_stage_vld_i     = 1'b0;
    bus.wb_pc_i               = $urandom;
    bus.wb_rd_vld_i           = 1'($urandom);
    bus.wb_rd_idx_i           = 5'($urandom);
    bus.wb_rd_i               = $urandom;
    bus.wb_rd_load_i          = 1'($urandom);
    bus.wb_rd_load_size_i     = 2'($urandom);
    bus.wb_rd_load_unsigned_i = 1'($urandom);
    bus.wb_rd_load_addr_i     = $urandom;
    bus.dmem_rsp_vld_i        = 1'b0;
    bus.dmem_rsp_data_i       = $urandom;
  endtask

  // Called at posedge+1. delay: cycles the response lags the load; early: response first.
  task automatic txn(input logic [31:0] pc, input bit rd_vld, input logic [4:0] idx,
                     input logic [31:0] rd, input bit is_load, input int size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] data,
                     input int delay, input bit early, input int gap);
    exp_t e;
    e.en   = rd_vld && (idx != 0);
    e.idx  = idx;
    e.data = is_load ? model_load(size, uns, int'(addr % 4), data) : rd;
    e.pc   = pc;
    if (is_load && early) begin
      bus.dmem_rsp_vld_i  = 1'b1;
      bus.dmem_rsp_data_i = data;
      @(posedge clk); #1;
      bus.dmem_rsp_vld_i  = 1'b0;
      bus.dmem_rsp_data_i = $urandom;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.ex2wb_stage_vld_i     = 1'b1;
    bus.wb_pc_i               = pc;
    bus.wb_rd_vld_i           = rd_vld;
    bus.wb_rd_idx_i           = idx;
    bus.wb_rd_i               = rd;
    bus.wb_rd_load_i          = is_load;
    bus.wb_rd_load_size_i     = 2'(size);
    bus.wb_rd_load_unsigned_i = uns;
    bus.wb_rd_load_addr_i     = addr;
    exp_q.push_back(e);
    if (is_load && !early) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check("rdy_while_waiting", bus.wb_stage_rdy_o, 0);
        @(posedge clk); #1;
      end
      bus.dmem_rsp_vld_i  = 1'b1;
      bus.dmem_rsp_data_i = data;
    end
    @(negedge clk);
    check("rdy_at_commit", bus.wb_stage_rdy_o, 1);
    @(posedge clk); #1;
    n_retired++;
    idle_inputs();
  endtask

  // Monitor: every retire pulse pops one expectation; otherwise no rf write may appear.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.wb_retire_vld_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rf_wr_en", bus.rf_wr_en_o, e.en);
          check("rf_wr_idx", bus.rf_wr_idx_o, e.idx);
          check("rf_wr_data", bus.rf_wr_data_o, e.data);
          check("retire_pc", bus.wb_retire_pc_o, e.pc);
        end
      end else begin
        check("rf_wr_en_idle", bus.rf_wr_en_o, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_pc, r_rd, r_addr, r_data;
    int          r_size, r_mode;
    idle_inputs();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rf_wr_en", bus.rf_wr_en_o, 0);
    check("reset_rf_wr_data", bus.rf_wr_data_o, 0);
    check("reset_retire_vld", bus.wb_retire_vld_o, 0);
    check("reset_retire_pc", bus.wb_retire_pc_o, 0);
    check("reset_rdy", bus.wb_stage_rdy_o, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(32'h100, 1, 5, 32'h1234, 0, 2, 0, 0, 0, 0, 0, 0);
    txn(32'h104, 1, 6, 32'h0, 1, 0, 0, 32'h1003, 32'h8000_0000, 0, 0, 0);
    txn(32'h108, 1, 7, 32'h0, 1, 0, 1, 32'h1003, 32'h8000_0000, 0, 0, 0);
    txn(32'h10c, 1, 8, 32'h0, 1, 1, 0, 32'h2002, 32'hBEEF_0000, 0, 0, 0);
    txn(32'h110, 1, 9, 32'h0, 1, 2, 0, 32'h3000, 32'hCAFE_F00D, 3, 0, 0);
    txn(32'h114, 1, 10, 32'h0, 1, 0, 0, 32'h4001, 32'h0000_9A00, 0, 1, 2);
    txn(32'h118, 1, 0, 32'hDEAD, 0, 2, 0, 0, 0, 0, 0, 0);
    txn(32'h11c, 1, 11, 32'h0, 1, 1, 1, 32'h5003, 32'hF123_4567, 1, 0, 0);

    // Reset while a load waits for its response.
    bus.ex2wb_stage_vld_i = 1'b1;
    bus.wb_pc_i           = 32'h200;
    bus.wb_rd_vld_i       = 1'b1;
    bus.wb_rd_idx_i       = 5'd12;
    bus.wb_rd_load_i      = 1'b1;
    bus.wb_rd_load_addr_i = 32'h0;
    @(negedge clk);
    check("rdy_wait_before_reset", bus.wb_stage_rdy_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_rf_wr_en", bus.rf_wr_en_o, 0);
    check("rst_wait_rf_wr_idx", bus.rf_wr_idx_o, 0);
    check("rst_wait_rf_wr_data", bus.rf_wr_data_o, 0);
    check("rst_wait_retire_vld", bus.wb_retire_vld_o, 0);
    check("rst_wait_retire_pc", bus.wb_retire_pc_o, 0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n     = 1'b1;
    n_retired = 0;
    @(posedge clk); #1;

    txn(32'h300, 1, 13, 32'h5555_AAAA, 0, 2, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      r_pc   = $urandom;
      r_rd   = $urandom;
      r_addr = $urandom;
      r_data = $urandom;
      r_size = $urandom_range(0, 3);
      r_mode = $urandom_range(0, 3);
      if (r_mode == 0) begin
        txn(r_pc, 1'($urandom), 5'($urandom), r_rd, 0, r_size, 1'($urandom), r_addr, r_data,
            0, 0, 0);
      end else if (r_mode == 1) begin
        txn(r_pc, 1'($urandom), 5'($urandom), r_rd, 1, r_size, 1'($urandom), r_addr, r_data,
            0, 0, 0);
      end else if (r_mode == 2) begin
        txn(r_pc, 1'($urandom), 5'($urandom), r_rd, 1, r_size, 1'($urandom), r_addr, r_data,
            $urandom_range(1, 4), 0, 0);
      end else begin
        txn(r_pc, 1'($urandom), 5'($urandom), r_rd, 1, r_size, 1'($urandom), r_addr, r_data,
            0, 1, $urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef K423_WB_RETIRE_CNT_EN
    check("instret", instret, n_retired);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
